// File: rtl/srl16_fifo_pkg.sv
// Shared constants and types for the SRL16-based FIFO.
// Address and count widths of the 16-deep shift-register column.
package srl16_fifo_pkg;
  localparam int SRL_DEPTH = 16;
  localparam int SRL_AW    = 4;

  typedef logic [SRL_AW-1:0] srl_addr_t;
  typedef logic [SRL_AW:0]   fifo_cnt_t;
endpackage

// File: rtl/my_SRL16E.sv
// Behavioural model of a 16-bit addressable shift register with clock enable.
// The contents have no reset, matching the LUT-based primitive.
module my_SRL16E (
  input  logic CLK,
  input  logic CE,
  input  logic D,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  output logic Q
);
  logic [15:0] sr_q;

  always_ff @(posedge CLK) begin
    if (CE) begin
      sr_q <= {sr_q[14:0], D};
    end
  end

  assign Q = sr_q[{A3, A2, A1, A0}];
endmodule

// File: rtl/srl16_fifo_ctrl.sv
// Occupancy counter and read-address tracker for the SRL16 FIFO.
// The read address always points at the oldest entry in the shift column.
module srl16_fifo_ctrl
  import srl16_fifo_pkg::*;
#(
  parameter int AFULL_LEVEL = 12
) (
  input  logic      clk_i,
  input  logic      srst_i,
  input  logic      in_valid_i,
  input  logic      out_ready_i,
  output logic      push_o,
  output logic      in_ready_o,
  output logic      out_valid_o,
  output fifo_cnt_t count_o,
  output srl_addr_t rd_addr_o,
  output logic      almost_full_o
);
  localparam fifo_cnt_t FULL_CNT  = fifo_cnt_t'(SRL_DEPTH);
  localparam fifo_cnt_t AFULL_CNT = fifo_cnt_t'(AFULL_LEVEL);

  fifo_cnt_t count_q, count_d;
  srl_addr_t rd_addr_q, rd_addr_d;
  logic      afull_q;
  logic      push, pop;

  assign in_ready_o  = (count_q != FULL_CNT);
  assign out_valid_o = (count_q != 5'd0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    count_d   = count_q;
    rd_addr_d = rd_addr_q;
    if (push && !pop) begin
      count_d = count_q + 5'd1;
      if (count_q != 5'd0) rd_addr_d = rd_addr_q + 4'd1;
    end else if (!push && pop) begin
      count_d = count_q - 5'd1;
      if (count_q != 5'd1) rd_addr_d = rd_addr_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_q   <= '0;
      rd_addr_q <= '0;
      afull_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      afull_q   <= (count_d >= AFULL_CNT);
    end
  end

  // Simulation-time invariants on the control state.
  always @(posedge clk_i) begin
    if (!srst_i) begin
      assert (count_q <= FULL_CNT);
      assert (count_q == 5'd0 || rd_addr_q == srl_addr_t'(count_q - 5'd1));
    end
  end

  assign push_o        = push;
  assign count_o       = count_q;
  assign rd_addr_o     = rd_addr_q;
  assign almost_full_o = afull_q;
endmodule

// File: rtl/srl16_fifo.sv
// First-word-fall-through FIFO, 16 deep, built from one SRL16 column per data bit.
// New data enters at address 0; the head is read at the tracked oldest address.
module srl16_fifo
  import srl16_fifo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int AFULL_LEVEL = 12
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       count,
  output logic             almost_full
);
  logic      push;
  srl_addr_t rd_addr;

  srl16_fifo_ctrl #(
    .AFULL_LEVEL(AFULL_LEVEL)
  ) u_ctrl (
    .clk_i        (C),
    .srst_i       (R),
    .in_valid_i   (in_valid),
    .out_ready_i  (out_ready),
    .push_o       (push),
    .in_ready_o   (in_ready),
    .out_valid_o  (out_valid),
    .count_o      (count),
    .rd_addr_o    (rd_addr),
    .almost_full_o(almost_full)
  );

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      my_SRL16E u_srl (
        .CLK(C),
        .CE (push),
        .D  (in_data[gi]),
        .A0 (rd_addr[0]),
        .A1 (rd_addr[1]),
        .A2 (rd_addr[2]),
        .A3 (rd_addr[3]),
        .Q  (out_data[gi])
      );
    end
  endgenerate
endmodule

// File: tb/tb_srl16_fifo.sv
// Directed bench for srl16_fifo: a vector table for basic fill/drain plus
// hand-written sequences for full, simultaneous push/pop and mid-run reset.
module tb_srl16_fifo;
  logic       C = 1'b0;
  logic       R = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic       almost_full;

  int checks = 0;
  int failures = 0;

  srl16_fifo #(.WIDTH(8), .AFULL_LEVEL(12)) dut (
    .C          (C),
    .R          (R),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .almost_full(almost_full)
  );

  always #5 C = ~C;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic [4:0] e_cnt;
    logic [3:0] e_rd;
    logic       e_ov;
    logic       e_ir;
    logic       e_af;
    logic       chk_dout;
    logic [7:0] e_dout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs, let one rising edge happen, then sample just after it.
  task automatic cycle(input logic rst, input logic iv, input logic [7:0] din, input logic ordy);
    R = rst; in_valid = iv; in_data = din; out_ready = ordy;
    @(posedge C);
    #1;
    R = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    //           rst   iv    din    ordy  cnt    rd     ov    ir    af    chk   dout
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'h11, 1'b0, 5'd1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[2] = '{1'b0, 1'b1, 8'h22, 1'b0, 5'd2, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[3] = '{1'b0, 1'b1, 8'h33, 1'b0, 5'd3, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd2, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

    @(posedge C);
    #1;

    // Tests 1 and 2: reset, three pushes, three pops, pop on empty.
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      check($sformatf("vec%0d count", i), count, vecs[i].e_cnt);
      check($sformatf("vec%0d rd_addr", i), dut.u_ctrl.rd_addr_q, vecs[i].e_rd);
      check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("vec%0d almost_full", i), almost_full, vecs[i].e_af);
      if (vecs[i].chk_dout) check($sformatf("vec%0d out_data", i), out_data, vecs[i].e_dout);
      $display("vec%0d count=%0d out_valid=%0b out_data=0x%02h", i, count, out_valid, out_data);
    end

    // Test 3: fill to 16, overflow attempt, drain in order.
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 1'b1, 8'(k), 1'b0);
      check($sformatf("fill%0d count", k), count, k + 1);
      check($sformatf("fill%0d almost_full", k), almost_full, (k + 1 >= 12) ? 1 : 0);
      check($sformatf("fill%0d in_ready", k), in_ready, (k == 15) ? 0 : 1);
      $display("fill push 0x%02h count=%0d afull=%0b", k, count, almost_full);
    end
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    check("overflow count", count, 16);
    check("overflow rd_addr", dut.u_ctrl.rd_addr_q, 15);
    check("overflow head", out_data, 8'h00);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain%0d head", k), out_data, k);
      check($sformatf("drain%0d out_valid", k), out_valid, 1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("drain%0d count", k), count, 15 - k);
      $display("drain pop count=%0d", count);
    end
    check("drained out_valid", out_valid, 0);
    check("drained almost_full", almost_full, 0);

    // Test 4: simultaneous push and pop at count 5.
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 8'h40 + 8'(k), 1'b0);
    check("pp start count", count, 5);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pp%0d head", k), out_data, 8'h40 + k);
      cycle(1'b0, 1'b1, 8'h45 + 8'(k), 1'b1);
      check($sformatf("pp%0d count", k), count, 5);
      check($sformatf("pp%0d rd_addr", k), dut.u_ctrl.rd_addr_q, 4);
      $display("pushpop %0d count=%0d head=0x%02h", k, count, out_data);
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ppdrain%0d head", k), out_data, 8'h44 + k);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
    end
    check("ppdrain count", count, 0);

    // Test 5: push and pop together when full; only the pop lands.
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, 8'h80 + 8'(k), 1'b0);
    check("full in_ready", in_ready, 0);
    check("full head", out_data, 8'h80);
    cycle(1'b0, 1'b1, 8'hBB, 1'b1);
    check("fullpp count", count, 15);
    check("fullpp in_ready", in_ready, 1);
    check("fullpp head", out_data, 8'h81);
    check("fullpp almost_full", almost_full, 1);
    $display("full pushpop count=%0d head=0x%02h", count, out_data);

    // Test 6: reset at count 7 with push and pop requested.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b1, 8'h60 + 8'(k), 1'b0);
    check("pre-reset count", count, 7);
    cycle(1'b1, 1'b1, 8'hEE, 1'b1);
    check("rst count", count, 0);
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst almost_full", almost_full, 0);
    check("rst rd_addr", dut.u_ctrl.rd_addr_q, 0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("rst idle out_valid", out_valid, 0);
    cycle(1'b0, 1'b1, 8'h5A, 1'b0);
    check("post-rst count", count, 1);
    check("post-rst out_valid", out_valid, 1);
    check("post-rst head", out_data, 8'h5A);
    $display("post reset push count=%0d head=0x%02h", count, out_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
